// File: rtl/mhsa_bar_sram_if.sv
// Host preload/readback channel of one SRAM bar.
// Request: valid/ready handshake carrying we/addr/wdata.
// Response: a single held read-data entry, consumed by rsp_ready.
//   master : host side (drives requests, consumes responses)
//   slave  : bank side (accepts requests, produces responses)
interface mhsa_bar_sram_if #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 32
);
    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_we;
    logic [ADDR_W-1:0] host_req_addr;
    logic [WIDTH-1:0]  host_req_wdata;
    logic              host_rsp_valid;
    logic [WIDTH-1:0]  host_rsp_data;
    logic              host_rsp_ready;

    modport master (
        output host_req_valid, host_req_we, host_req_addr, host_req_wdata, host_rsp_ready,
        input  host_req_ready, host_rsp_valid, host_rsp_data
    );

    modport slave (
        input  host_req_valid, host_req_we, host_req_addr, host_req_wdata, host_rsp_ready,
        output host_req_ready, host_rsp_valid, host_rsp_data
    );
endinterface

// File: rtl/mhsa_bar_sram.sv
// One single-port word bank of the accelerator's SRAM bar, shared between
// the accelerator port and the host preload/readback channel.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   acc_en        accelerator owns the bank this cycle
//   write_en      accelerator write strobe
//   data_in       accelerator write data
//   addr          accelerator word address
//   data_out      accelerator read data, 1-cycle latency, read-first
//   oob_err       sticky out-of-range address flag
//   oob_clr       clears oob_err (a same-cycle set wins)
//   host          host request/response channel (slave side)
module mhsa_bar_sram #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_en,
    input  logic              write_en,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  data_out,
    output logic              oob_err,
    input  logic              oob_clr,
    mhsa_bar_sram_if.slave    host
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_HOST = 2'd0,
        ST_ACC  = 2'd1,
        ST_TURN = 2'd2
    } owner_t;

    owner_t state_q, state_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             req_ready;
    logic             host_fire;
    logic             acc_inr;
    logic             host_inr;
    logic             oob_set;
    logic [IDX_W-1:0] mem_idx;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic             rsp_vld_p1;
    logic [WIDTH-1:0] rsp_data_p1;

    // Ownership FSM. TURN holds the host off for one cycle after the
    // accelerator lets go so its final read drains first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_HOST;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            ST_HOST: begin
                if (acc_en) state_d = ST_ACC;
                req_ready = !acc_en && (!rsp_vld_p1 || host.host_rsp_ready);
            end
            ST_ACC:  if (!acc_en) state_d = ST_TURN;
            ST_TURN: state_d = acc_en ? ST_ACC : ST_HOST;
            default: state_d = ST_HOST;
        endcase
    end

    assign host_fire = host.host_req_valid && req_ready;
    assign acc_inr   = addr < DEPTH_A;
    assign host_inr  = host.host_req_addr < DEPTH_A;

    // Single port: host_fire implies !acc_en, so the mux never sees two users.
    assign mem_idx   = acc_en ? addr[IDX_W-1:0] : host.host_req_addr[IDX_W-1:0];
    assign mem_wdata = acc_en ? data_in : host.host_req_wdata;
    assign mem_we    = acc_en ? (write_en && acc_inr)
                              : (host_fire && host.host_req_we && host_inr);
    assign oob_set   = (acc_en && !acc_inr) || (host_fire && !host_inr);

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wdata;
    end

    // Read stage: both read registers sample the old word (read-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out    <= '0;
            rsp_vld_p1  <= 1'b0;
            rsp_data_p1 <= '0;
            oob_err     <= 1'b0;
        end else begin
            if (acc_en)
                data_out <= acc_inr ? mem[mem_idx] : '0;

            if (host_fire && !host.host_req_we) begin
                rsp_vld_p1  <= 1'b1;
                rsp_data_p1 <= host_inr ? mem[mem_idx] : '0;
            end else if (host.host_rsp_ready) begin
                rsp_vld_p1  <= 1'b0;
            end

            if (oob_set)      oob_err <= 1'b1;
            else if (oob_clr) oob_err <= 1'b0;
        end
    end

    assign host.host_req_ready = req_ready;
    assign host.host_rsp_valid = rsp_vld_p1;
    assign host.host_rsp_data  = rsp_data_p1;

endmodule

// File: tb/tb_mhsa_bar_sram.sv
module tb_mhsa_bar_sram;
    localparam int WIDTH  = 64;
    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              acc_en;
    logic              write_en;
    logic [WIDTH-1:0]  data_in;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data_out;
    logic              oob_err;
    logic              oob_clr;

    always #5 clk = ~clk;

    mhsa_bar_sram_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) hif ();

    mhsa_bar_sram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .acc_en   (acc_en),
        .write_en (write_en),
        .data_in  (data_in),
        .addr     (addr),
        .data_out (data_out),
        .oob_err  (oob_err),
        .oob_clr  (oob_clr),
        .host     (hif)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: a sparse word store plus the observable registers.
    // The host may touch the bank only after acc_en has been low at the
    // two preceding clock edges (release edge + one turnaround cycle).
    logic [63:0] mmem [logic [31:0]];
    logic [63:0] m_dout, m_rd;
    logic        m_rv, m_oob, m_acc1, m_acc2;
    logic [63:0] pre [16];

    function automatic logic [63:0] mread(input logic [31:0] a);
        if (a >= DEPTH) return 64'd0;
        if (mmem.exists(a)) return mmem[a];
        return 'x;
    endfunction

    task automatic model_reset();
        m_dout = '0; m_rd = '0; m_rv = 1'b0; m_oob = 1'b0; m_acc1 = 1'b0; m_acc2 = 1'b0;
    endtask

    task automatic model_step(input logic rdy);
        logic fire, set;
        if (rst) begin
            model_reset();
            return;
        end
        fire = hif.host_req_valid && rdy;
        set  = 1'b0;
        if (acc_en) begin
            m_dout = mread(addr);
            if (addr >= DEPTH) set = 1'b1;
            else if (write_en) mmem[addr] = data_in;
        end
        if (m_rv && hif.host_rsp_ready) m_rv = 1'b0;
        if (fire) begin
            if (hif.host_req_addr >= DEPTH) set = 1'b1;
            if (hif.host_req_we) begin
                if (hif.host_req_addr < DEPTH) mmem[hif.host_req_addr] = hif.host_req_wdata;
            end else begin
                m_rv = 1'b1;
                m_rd = mread(hif.host_req_addr);
            end
        end
        if (set) m_oob = 1'b1;
        else if (oob_clr) m_oob = 1'b0;
        m_acc2 = m_acc1;
        m_acc1 = acc_en;
    endtask

    // Compare all outputs on the falling edge, advance the model, return
    // 1ns after the next rising edge so the caller can drive new inputs.
    task automatic cycle();
        logic exp_rdy;
        @(negedge clk);
        exp_rdy = !m_acc1 && !m_acc2 && !acc_en && (!m_rv || hif.host_rsp_ready);
        check("req_ready", hif.host_req_ready, exp_rdy);
        check("data_out",  data_out,           m_dout);
        check("rsp_valid", hif.host_rsp_valid, m_rv);
        check("rsp_data",  hif.host_rsp_data,  m_rd);
        check("oob_err",   oob_err,            m_oob);
        model_step(exp_rdy);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8)  return 32'($urandom_range(0, 15));
        if (r == 8) return 32'(DEPTH + $urandom_range(0, 3));
        return 32'hFFFF_0000 | 32'($urandom_range(0, 255));
    endfunction

    initial begin
        rst = 1'b1; acc_en = 1'b0; write_en = 1'b0; oob_clr = 1'b0;
        data_in = '0; addr = '0;
        hif.host_req_valid = 1'b0; hif.host_req_we = 1'b0; hif.host_req_addr = '0;
        hif.host_req_wdata = '0; hif.host_rsp_ready = 1'b0;
        model_reset();
        #2;
        check("rst_data_out",  data_out,           64'd0);
        check("rst_rsp_valid", hif.host_rsp_valid, 64'd0);
        check("rst_rsp_data",  hif.host_rsp_data,  64'd0);
        check("rst_oob",       oob_err,            64'd0);
        cycle();
        rst = 1'b0;

        // Preload words 0..15.
        for (int i = 0; i < 16; i++) begin
            pre[i] = {$urandom(), $urandom()};
            hif.host_req_valid = 1'b1; hif.host_req_we = 1'b1;
            hif.host_req_addr = 32'(i); hif.host_req_wdata = pre[i];
            cycle();
        end

        // Host write then read of addr 5, response held for 3 cycles.
        hif.host_req_addr = 32'd5; hif.host_req_wdata = 64'h1122334455667788;
        cycle();
        hif.host_req_we = 1'b0;
        cycle();
        hif.host_req_valid = 1'b0;
        check("hold_valid0", hif.host_rsp_valid, 64'd1);
        check("hold_data0",  hif.host_rsp_data,  64'h1122334455667788);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_valid", hif.host_rsp_valid, 64'd1);
            check("hold_data",  hif.host_rsp_data,  64'h1122334455667788);
            check("hold_ready", hif.host_req_ready, 64'd0);
        end
        hif.host_rsp_ready = 1'b1;
        cycle();
        check("rsp_drop", hif.host_rsp_valid, 64'd0);

        // Accelerator read-first write, then read back.
        acc_en = 1'b1; addr = 32'd5; write_en = 1'b1; data_in = 64'hAA;
        cycle();
        check("acc_read_first", data_out, 64'h1122334455667788);
        write_en = 1'b0;
        cycle();
        check("acc_readback", data_out, 64'hAA);

        // Arbitration and turnaround.
        hif.host_req_valid = 1'b1; hif.host_req_we = 1'b0; hif.host_req_addr = 32'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("arb_ready", hif.host_req_ready, 64'd0);
            cycle();
        end
        acc_en = 1'b0;
        #1;
        check("release_ready", hif.host_req_ready, 64'd0);
        cycle();
        check("turn_ready", hif.host_req_ready, 64'd0);
        cycle();
        check("host_ready", hif.host_req_ready, 64'd1);
        cycle();
        hif.host_req_valid = 1'b0;
        check("arb_rsp_data", hif.host_rsp_data, pre[3]);

        // Out-of-range accesses and oob_err set/clear.
        acc_en = 1'b1; write_en = 1'b1; addr = 32'd4096; data_in = 64'hDEAD;
        cycle();
        check("oob_set", oob_err, 64'd1);
        write_en = 1'b0; addr = 32'd0;
        cycle();
        check("oob_no_alias", data_out, pre[0]);
        addr = 32'd4096; oob_clr = 1'b1;
        cycle();
        check("oob_set_wins", oob_err, 64'd1);
        acc_en = 1'b0; addr = 32'd0;
        cycle();
        check("oob_clear", oob_err, 64'd0);
        oob_clr = 1'b0;
        cycle();
        cycle();
        hif.host_req_valid = 1'b1; hif.host_req_addr = 32'hFFFF_FFFF;
        cycle();
        hif.host_req_valid = 1'b0;
        check("oob_rsp_valid", hif.host_rsp_valid, 64'd1);
        check("oob_rsp_data",  hif.host_rsp_data,  64'd0);
        check("oob_host_set",  oob_err,            64'd1);
        oob_clr = 1'b1;
        cycle();
        oob_clr = 1'b0;

        // Back-to-back host reads of 0,1,2.
        hif.host_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hif.host_req_addr = 32'(i);
            cycle();
            check("b2b_valid", hif.host_rsp_valid, 64'd1);
            check("b2b_data",  hif.host_rsp_data,  pre[i]);
        end
        hif.host_req_valid = 1'b0;
        cycle();
        check("b2b_end", hif.host_rsp_valid, 64'd0);

        // Reset while a response is pending.
        hif.host_req_valid = 1'b1; hif.host_req_addr = 32'd7; hif.host_rsp_ready = 1'b0;
        cycle();
        hif.host_req_valid = 1'b0;
        check("pend_valid", hif.host_rsp_valid, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rsp_valid", hif.host_rsp_valid, 64'd0);
        check("arst_data_out",  data_out,           64'd0);
        check("arst_oob",       oob_err,            64'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        #1;
        check("post_rst_ready", hif.host_req_ready, 64'd1);
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) acc_en = !acc_en;
            write_en           = 1'($urandom_range(0, 1));
            addr               = pick_addr();
            data_in            = {$urandom(), $urandom()};
            hif.host_req_valid = 1'($urandom_range(0, 1));
            hif.host_req_we    = 1'($urandom_range(0, 1));
            hif.host_req_addr  = pick_addr();
            hif.host_req_wdata = {$urandom(), $urandom()};
            hif.host_rsp_ready = ($urandom_range(0, 3) != 0);
            oob_clr            = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mhsa_bar_sram.md
Name: mhsa_bar_sram

Overview:
- Responder side of the accelerator's unified SRAM "bar" interface: one single-port word memory bank per bar.
- Serves the accelerator port (write_en/data_in/addr/data_out) with fixed 1-cycle read latency.
- Also serves a host preload/readback port with valid/ready handshake and a one-entry response buffer.
- Four instances sit beside the accelerator top, one per bar.

Parameters:
WIDTH, 64, data word width in bits
DEPTH, 4096, number of words in the bank; valid word addresses 0..DEPTH-1
ADDR_W, 32, address port width

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
acc_en  input  1  accelerator owns the bank (driven high while the top FSM is in a compute state)
write_en  input  1  accelerator write strobe
data_in  input  WIDTH  accelerator write data
addr  input  ADDR_W  accelerator word address
data_out  output  WIDTH  accelerator read data, registered
host_req_valid  input  1  host request valid
host_req_ready  output  1  host request accepted when valid&ready
host_req_we  input  1  1=write, 0=read
host_req_addr  input  ADDR_W  host word address
host_req_wdata  input  WIDTH  host write data
host_rsp_valid  output  1  host read data valid
host_rsp_data  output  WIDTH  host read data
host_rsp_ready  input  1  host consumes response
oob_err  output  1  sticky out-of-range address flag
oob_clr  input  1  clears oob_err

Behaviour:
- Reset (async, rst=1): data_out=0, host_rsp_valid=0, host_rsp_data=0, oob_err=0, owner FSM=HOST. Memory contents are not reset (X in simulation). Reset during a pending host response drops that response.
- Owner FSM states are HOST, ACC and TURN:
  - HOST->ACC when acc_en=1.
  - ACC->TURN when acc_en=0.
  - TURN->ACC if acc_en=1, else TURN->HOST.
  - TURN lasts exactly one cycle so the final accelerator read completes before the host touches the bank.
- Accelerator port is active whenever acc_en=1, combinationally, independent of FSM state. It is never stalled (the interface has no ready).
  - Every active cycle with an in-range addr: data_out <= mem[addr] at the clock edge, visible the cycle after addr is presented (1-cycle latency).
  - If write_en=1 in that cycle, mem[addr] <= data_in. The read is read-first: data_out gets the old contents.
  - When acc_en=0, data_out holds its last value.
- host_req_ready = (state==HOST) && !acc_en && (!host_rsp_valid || host_rsp_ready).
  - If acc_en and host_req_valid are both high in the same cycle, the accelerator wins and the host is not accepted.
- Host write accepted: mem[host_req_addr] <= host_req_wdata at that edge. Writes are posted and produce no response.
- Host read accepted: the next cycle, host_rsp_valid=1 and host_rsp_data=mem[host_req_addr].
  - Valid and data are held stable until host_rsp_ready=1.
  - host_rsp_valid clears the cycle after the handshake unless a new read was accepted in the handshake cycle; back-to-back reads then give 1 read per cycle.
- A response pending when acc_en rises is still held and delivered. Only new acceptance is blocked.
- Out of range (addr >= DEPTH, full ADDR_W compare):
  - Applies to an active accelerator access or an accepted host request.
  - Writes are dropped; reads return 0 (data_out=0 or host_rsp_data=0).
  - oob_err=1 from the next cycle and stays set until oob_clr=1.
  - If set and clear happen in the same cycle, set wins.
- Memory is inferable as single-port RAM: at most one access per cycle, guaranteed by the ownership rules above.

Test Plan:
- Host preload then readback: with acc_en=0, host writes addr 5 = 0x1122334455667788 (no response); host reads addr 5 -> host_rsp_valid=1 next cycle with that data. Hold host_rsp_ready=0 for 3 cycles -> valid and data stable; host_req_ready=0 during the hold.
- Accelerator latency and read-first:
  - acc_en=1, addr=5, write_en=1, data_in=0xAA -> data_out=0x1122334455667788 next cycle.
  - Then addr=5, write_en=0 -> data_out=0xAA next cycle.
- Arbitration and turnaround: host_req_valid=1 held while acc_en=1 -> host_req_ready=0 throughout. Drop acc_en -> host_req_ready stays 0 for exactly one TURN cycle, then 1.
- Out of range:
  - Accelerator write addr=4096 -> memory unchanged, oob_err=1 next cycle.
  - Host read addr=0xFFFFFFFF -> rsp data 0.
  - oob_clr with a simultaneous new OOB access -> oob_err stays 1; oob_clr alone -> oob_err=0.
- Back-to-back host reads of addrs 0,1,2 with host_rsp_ready=1 -> responses on 3 consecutive cycles in order.
- Reset mid-response: assert rst while host_rsp_valid=1 -> host_rsp_valid=0, data_out=0, oob_err=0 immediately (asynchronous). After release, host_req_ready=1 with acc_en=0.
